// File: rtl/apb_rr_master_arbiter.sv
// rtl/apb_rr_master_arbiter.sv - round-robin APB master sharing one bus (GPIO/UART) among NREQ requesters
// Optional ACCESS-phase timeout abort enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_master_arbiter #(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef APB_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 255
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ-1:0]        req_wr,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        done,
  output logic                   err,
  output logic [DATA_W-1:0]      rdata,
  output logic [1:0]             psel,
  output logic                   penable,
  output logic                   pwrite,
  output logic [ADDR_W-1:0]      paddr,
  output logic [DATA_W-1:0]      pwdata,
  input  logic [DATA_W-1:0]      prdata,
  input  logic                   pready
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [PW-1:0]     win_q, win_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              slv_q, slv_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] tcnt_q, tcnt_d;
`endif

  // First asserted request at or after the pointer, wrapping.
  logic              found;
  logic [PW-1:0]     grant;
  logic [PW-1:0]     idx;
  logic [ADDR_W-1:0] addr_g;

  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
    addr_g = req_addr[int'(grant)*ADDR_W +: ADDR_W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    slv_d   = slv_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef APB_ARB_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = grant;
          ptr_d   = PW'((int'(grant) + 1) % NREQ);
          wr_d    = req_wr[grant];
          addr_d  = addr_g;
          wdata_d = req_wdata[int'(grant)*DATA_W +: DATA_W];
          err_d   = 1'b0;
          rdata_d = '0;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt_d  = '0;
`endif
          case (addr_g[15:12])
            4'h0: begin slv_d = 1'b0; state_d = SETUP; end
            4'h1: begin slv_d = 1'b1; state_d = SETUP; end
            default: begin err_d = 1'b1; state_d = RESP; end
          endcase
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (!wr_q) rdata_d = prdata;
          state_d = RESP;
        end
`ifdef APB_ARB_TIMEOUT_EN
        else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      slv_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      slv_q   <= slv_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
`endif
    end
  end

  // Bus and response outputs decode straight from the registered state.
  assign psel    = ((state_q == SETUP) || (state_q == ACCESS)) ? (slv_q ? 2'b10 : 2'b01) : 2'b00;
  assign penable = (state_q == ACCESS);
  assign pwrite  = wr_q;
  assign paddr   = addr_q;
  assign pwdata  = wdata_q;
  assign done    = (state_q == RESP) ? (NREQ'(1) << win_q) : '0;
  assign err     = (state_q == RESP) && err_q;
  assign rdata   = (state_q == RESP) ? rdata_q : '0;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb/tb_apb_rr_master_arbiter.sv - directed scoreboard bench for apb_rr_master_arbiter
module tb_apb_rr_master_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_wr;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  done;
  logic        err;
  logic [31:0] rdata;
  logic [1:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  d;
    logic        e;
    logic [31:0] r;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  apb_rr_master_arbiter #(
    .NREQ(2), .ADDR_W(32), .DATA_W(32)
`ifdef APB_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(4)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic e, input logic [31:0] r);
    exp_t x;
    x.d = d; x.e = e; x.r = r;
    sb.push_back(x);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done !== 2'b00) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_done", {62'd0, done}, 64'd0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("sb_done", {62'd0, done}, {62'd0, x.d});
        chk("sb_err", {63'd0, err}, {63'd0, x.e});
        chk("sb_rdata", {32'd0, rdata}, {32'd0, x.r});
      end
    end
  end

  initial begin
    int ndone;
    int last;
    logic got;
    rst_n = 1'b0; req = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    prdata = '0; pready = 1'b1;
    repeat (3) tick();
    chk("rst_psel", {62'd0, psel}, 64'd0);
    chk("rst_penable", {63'd0, penable}, 64'd0);
    chk("rst_done", {62'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_rdata", {32'd0, rdata}, 64'd0);
    chk("rst_paddr_pwdata", {paddr, pwdata}, 64'd0);
    chk("rst_pwrite", {63'd0, pwrite}, 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single write to UART, no wait states
    prdata = 32'hDEADBEEF;
    req = 2'b01; req_wr = 2'b01; req_addr[31:0] = 32'h0000_1004; req_wdata[31:0] = 32'hA5A5A5A5;
    push(2'b01, 1'b0, 32'h0);
    tick();
    chk("t1_setup_psel", {62'd0, psel}, 64'h2);
    chk("t1_setup_penable", {63'd0, penable}, 64'd0);
    chk("t1_paddr", {32'd0, paddr}, 64'h1004);
    chk("t1_pwdata_pwrite", {31'd0, pwrite, pwdata}, {31'd0, 1'b1, 32'hA5A5A5A5});
    tick();
    chk("t1_access", {61'd0, psel, penable}, 64'h5);
    tick();
    chk("t1_done", {61'd0, done, err}, 64'h2);
    chk("t1_resp_bus", {61'd0, psel, penable}, 64'd0);
    req = 2'b00;
    tick();
    chk("t1_done_clear", {61'd0, done, err}, 64'd0);

    // 2: read from GPIO with 3 wait states
    prdata = 32'h12345678; pready = 1'b0;
    req = 2'b10; req_wr = 2'b00; req_addr[63:32] = 32'h0000_0008;
    push(2'b10, 1'b0, 32'h12345678);
    tick();
    chk("t2_setup", {61'd0, psel, penable}, 64'h2);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t2_access_hold", {61'd0, psel, penable, done}, {61'd0, 2'b01, 1'b1, 2'b00});
      pready = (i == 3);
      tick();
    end
    chk("t2_done", {62'd0, done}, 64'h2);
    chk("t2_rdata", {32'd0, rdata}, 64'h12345678);
    req = 2'b00;
    tick();
    chk("t2_rdata_clear", {32'd0, rdata}, 64'd0);

    // 3: contention, grants alternate and complete every 4 cycles
    prdata = 32'h0BADF00D;
    req = 2'b11; req_wr = 2'b01;
    req_addr = {32'h0000_1020, 32'h0000_0010};
    req_wdata = {32'h1111_1111, 32'h2222_2222};
    push(2'b01, 1'b0, 32'h0);
    push(2'b10, 1'b0, 32'h0BADF00D);
    push(2'b01, 1'b0, 32'h0);
    push(2'b10, 1'b0, 32'h0BADF00D);
    ndone = 0; last = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (done !== 2'b00) begin
        ndone++;
        if (ndone > 1) chk("t3_spacing", 64'(c - last), 64'd4);
        last = c;
        if (ndone == 4) begin
          req = 2'b00;
          break;
        end
      end
    end
    chk("t3_count", 64'(ndone), 64'd4);
    tick();

    // 4: decode error, no bus cycle
    req = 2'b01; req_wr = 2'b00; req_addr[31:0] = 32'h0000_5000;
    push(2'b01, 1'b1, 32'h0);
    tick();
    chk("t4_resp", {59'd0, psel, penable, done, err}, {59'd0, 2'b00, 1'b0, 2'b01, 1'b1});
    req = 2'b00;
    tick();
    chk("t4_clear", {61'd0, done, err}, 64'd0);

    // 5: reset mid-ACCESS, then fresh request from requester 1
    pready = 1'b0;
    req = 2'b01; req_wr = 2'b01; req_addr[31:0] = 32'h0000_0004;
    tick();
    tick();
    chk("t5_in_access", {63'd0, penable}, 64'd1);
    rst_n = 1'b0; req = 2'b00;
    tick();
    chk("t5_abort", {59'd0, psel, penable, done}, 64'd0);
    rst_n = 1'b1; pready = 1'b1; prdata = 32'hCAFE0001;
    req = 2'b10; req_wr = 2'b00; req_addr[63:32] = 32'h0000_1000;
    push(2'b10, 1'b0, 32'hCAFE0001);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (done !== 2'b00) got = 1'b1;
    end
    chk("t5_done_seen", {63'd0, got}, 64'd1);
    req = 2'b00;
    tick();

    // 6: slave never ready
    pready = 1'b0;
    req = 2'b01; req_wr = 2'b00; req_addr[31:0] = 32'h0000_0000;
`ifdef APB_ARB_TIMEOUT_EN
    push(2'b01, 1'b1, 32'h0);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("t6_access", {62'd0, penable, done != 2'b00}, 64'h2);
      tick();
    end
    chk("t6_timeout", {60'd0, psel, done, err}, {60'd0, 2'b00, 2'b01, 1'b1});
    req = 2'b00;
    tick();
`else
    ndone = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (done !== 2'b00) ndone++;
    end
    chk("t6_no_done", 64'(ndone), 64'd0);
    chk("t6_still_access", {62'd0, psel, penable} >> 0, {61'd0, 2'b01, 1'b1});
    rst_n = 1'b0; req = 2'b00;
    tick();
    rst_n = 1'b1;
    tick();
`endif

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
